bf16_add_sched: RTL and testbench

- Round-robin scheduler that shares one bfloat16 adder datapath among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready, issues one operation at a time to the adder, and returns the sum tagged with the requester id.
- Sits between client engines and the single shared adder instance.
- Provides a timeout fallback if the adder never signals completion.

---
 rtl/bf16_sched_pkg.sv | 6 +
 rtl/bf16_add_sched_rr_arbiter.sv | 27 ++
 rtl/bf16_add_sched.sv | 91 +++++++++
 tb/tb_bf16_add_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bf16_sched_pkg.sv
// bf16_sched_pkg: shared types and constants for the bfloat16 adder scheduler.
package bf16_sched_pkg;
    localparam int BF16_W = 16;
    localparam logic [BF16_W-1:0] BF16_QNAN = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/bf16_add_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    localparam logic [IDW:0] N = (IDW + 1)'(NREQ);
    logic [2*NREQ-1:0] dbl;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;
    // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner.
    assign dbl = {req, req} >> ptr;
    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (dbl[k]) off = IDW'(k);
    end
    assign sum   = {1'b0, ptr} + {1'b0, off};
    assign idx   = sum >= N ? IDW'(sum - N) : IDW'(sum);
    assign any   = |req;
    assign grant = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/bf16_add_sched.sv
// bf16_add_sched: round-robin sharing of one bfloat16 adder among NREQ requesters,
// with a timeout fallback that returns a NaN flagged as an error.
module bf16_add_sched
    import bf16_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LAT     = 3,
    parameter int TIMEOUT = 15,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*BF16_W-1:0] req_a,
    input  logic [NREQ*BF16_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [BF16_W-1:0]      rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_err,
    output logic                   add_start,
    output logic [BF16_W-1:0]      add_a,
    output logic [BF16_W-1:0]      add_b,
    input  logic [BF16_W-1:0]      add_sum,
    input  logic                   add_done,
    output logic                   busy,
    output logic                   stray_done
);
    localparam int CW = $clog2(TIMEOUT + 1);

    if (TIMEOUT <= LAT) begin : g_bad_timeout
        $error("TIMEOUT must exceed LAT");
    end

    state_t          state;
    logic [IDW-1:0]  ptr, g;
    logic [NREQ-1:0] grant;
    logic            any;
    logic [CW-1:0]   cnt;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req(req_valid), .ptr(ptr), .grant(grant), .idx(g), .any(any)
    );

    assign req_ready = state == IDLE ? grant : '0;
    assign rsp_valid = state == RESP;
    assign add_start = state == ISSUE;
    assign busy      = state != IDLE;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            add_a      <= '0;
            add_b      <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            stray_done <= 1'b0;
        end else begin
            if (add_done && state != WAIT) stray_done <= 1'b1;
            case (state)
                IDLE: if (any) begin
                    add_a  <= req_a[g*BF16_W +: BF16_W];
                    add_b  <= req_b[g*BF16_W +: BF16_W];
                    rsp_id <= g;
                    ptr    <= g == IDW'(NREQ - 1) ? '0 : g + 1'b1;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= CW'(1);
                    state <= WAIT;
                end
                WAIT: if (add_done) begin
                    rsp_data <= add_sum;
                    rsp_err  <= 1'b0;
                    state    <= RESP;
                end else if (cnt == CW'(TIMEOUT)) begin
                    rsp_data <= BF16_QNAN;
                    rsp_err  <= 1'b1;
                    state    <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: if (rsp_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_add_sched.sv
// tb_bf16_add_sched: randomized and directed checks of the shared-adder scheduler
// against a transaction-level reference model.
module tb_bf16_add_sched;
    localparam int NREQ = 4, LAT = 3, TIMEOUT = 15, IDW = 2;

    logic                clock = 1'b0, nreset = 1'b0;
    logic [NREQ-1:0]     req_valid = '0, req_ready;
    logic [NREQ*16-1:0]  req_a = '0, req_b = '0;
    logic                rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [15:0]         rsp_data, add_a, add_b, add_sum = '0;
    logic [IDW-1:0]      rsp_id;
    logic                add_start, add_done = 1'b0, busy, stray_done;

    always #5 clock = ~clock;

    bf16_add_sched #(.NREQ(NREQ), .LAT(LAT), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clock(clock), .nreset(nreset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_done(add_done), .busy(busy), .stray_done(stray_done)
    );

    int n_vec = 0, n_err = 0, cyc = 0;
    int acc_c = 0, exp_rsp = 0, done_at = -1, e_id = 0, mptr = 0;
    int force_k = -2, req_mode = 0, rdy_mode = 1;
    bit outst = 0, e_err = 0, e_stray = 0, stray_now = 0;
    logic [15:0] e_a = '0, e_b = '0, e_data = '0;
    logic [NREQ-1:0] pend = '0;
    logic [15:0] opa [NREQ];
    logic [15:0] opb [NREQ];
    int gq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Stand-in adder: routing is what matters, so a plain integer sum is enough.
    function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
        return (a == 16'h3F80 && b == 16'h4000) ? 16'h4040 : a + b;
    endfunction

    function automatic int rr_pick();
        for (int k = 0; k < NREQ; k++)
            if (pend[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        return -1;
    endfunction

    task automatic chk_zero();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_add_start", 32'(add_start), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_add_b", 32'(add_b), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stray", 32'(stray_done), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        nreset = 1'b0; pend = '0; req_valid = '0; add_done = 1'b0; rsp_ready = 1'b0;
        @(negedge clock);
        nreset = 1'b1;
        outst = 0; mptr = 0; e_stray = 0; done_at = -1; exp_rsp = 1 << 30;
        chk_zero();
    endtask

    task automatic step();
        int k, g;
        bit rv_exp;
        @(negedge clock);
        cyc++;
        chk("busy", 32'(busy), 32'(outst));
        chk("add_start", 32'(add_start), 32'(outst && cyc == acc_c + 1));
        if (outst && cyc == acc_c + 1) begin
            chk("add_a", 32'(add_a), 32'(e_a));
            chk("add_b", 32'(add_b), 32'(e_b));
            if (force_k != -2) k = force_k;
            else begin
                k = $urandom % 8;
                k = k < 4 ? LAT : k < 7 ? int'($urandom_range(1, TIMEOUT)) : -1;
            end
            if (k < 0) begin
                done_at = -1; exp_rsp = cyc + TIMEOUT + 1; e_data = 16'hFFFF; e_err = 1;
            end else begin
                done_at = cyc + k; exp_rsp = done_at + 1; e_data = model_sum(e_a, e_b); e_err = 0;
            end
        end
        rv_exp = outst && cyc >= exp_rsp;
        chk("rsp_valid", 32'(rsp_valid), 32'(rv_exp));
        if (rv_exp) begin
            chk("rsp_data", 32'(rsp_data), 32'(e_data));
            chk("rsp_id", 32'(rsp_id), 32'(e_id));
            chk("rsp_err", 32'(rsp_err), 32'(e_err));
        end
        chk("stray_done", 32'(stray_done), 32'(e_stray));
        add_done = (cyc == done_at) || stray_now;
        add_sum = cyc == done_at ? model_sum(e_a, e_b) : 16'($urandom);
        e_stray |= stray_now;
        stray_now = 0;
        for (int i = 0; i < NREQ; i++)
            if (!pend[i] && (req_mode == 1 || (req_mode == 2 && $urandom % 3 == 0))) begin
                pend[i] = 1'b1; opa[i] = 16'($urandom); opb[i] = 16'($urandom);
            end
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = opa[i];
            req_b[16*i +: 16] = opb[i];
        end
        rsp_ready = rdy_mode == 2 ? ($urandom % 4 != 0) : rdy_mode[0];
        #1;
        g = outst ? -1 : rr_pick();
        chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'(1 << g));
        if (g >= 0) begin
            pend[g] = 1'b0; e_id = g; e_a = opa[g]; e_b = opb[g];
            mptr = (g + 1) % NREQ; outst = 1; acc_c = cyc; exp_rsp = 1 << 30; done_at = -1;
            gq.push_back(g);
        end else if (rv_exp && rsp_ready) outst = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        do_reset();
        // single operation with the nominal adder latency
        req_mode = 0; rdy_mode = 1; force_k = LAT;
        opa[0] = 16'h3F80; opb[0] = 16'h4000; pend = 4'b0001;
        run(10);
        // fairness with every requester asserting
        do_reset();
        gq.delete();
        req_mode = 1;
        run(40);
        req_mode = 0; pend = '0;
        run(20);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fair_grant%0d", i), gq.size() > i ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(i % NREQ));
        // backpressure in RESP
        rdy_mode = 0; pend[1] = 1'b1; opa[1] = 16'h1234; opb[1] = 16'h0101;
        run(8);
        pend[2] = 1'b1; opa[2] = 16'h00AA; opb[2] = 16'h0055;
        run(10);
        rdy_mode = 1;
        run(12);
        // timeout, then a late done while the response is held
        force_k = -1; rdy_mode = 0; pend[0] = 1'b1; opa[0] = 16'h4100; opb[0] = 16'h4200;
        run(22);
        stray_now = 1;
        run(2);
        rdy_mode = 1;
        run(5);
        // done on the last possible WAIT cycle
        force_k = TIMEOUT; pend[3] = 1'b1; opa[3] = 16'h0F0F; opb[3] = 16'h0001;
        run(22);
        // pointer wrap
        do_reset();
        force_k = LAT; pend = 4'b1000;
        run(10);
        pend = 4'b0100;
        run(10);
        pend = 4'b1001;
        run(10);
        // reset during WAIT abandons the op; a later done is stray
        force_k = -1; pend = 4'b0010;
        run(4);
        do_reset();
        stray_now = 1;
        run(3);
        // randomized traffic
        do_reset();
        req_mode = 2; rdy_mode = 2; force_k = -2;
        run(3000);
        req_mode = 0; rdy_mode = 1;
        run(40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
